vga_timing: RTL and testbench

Raster timing generator feeding the pixel colour stage. It produces the column/row pixel address and the `ready` (active-video) qualifier that the colour generator consumes, plus horizontal/vertical sync. Sync outputs have a programmable pipeline delay so they stay aligned with the downstream registered RGB.

---
 rtl/vga_timing.sv | 118 +++++++++++
 tb/tb_vga_timing.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Raster timing generator: pixel address, active-video qualifier, frame pulse
// and programmable-delay h/v sync, all advancing on the pix_en tick.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned SYNC_DLY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] col_addr,
    output logic [10:0] row_addr,
    output logic        ready,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DLY_W   = SYNC_DLY + 1;

    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE - 1);
    localparam logic [10:0] H_FP_END  = 11'(H_ACTIVE + H_FP - 1);
    localparam logic [10:0] H_SYN_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE - 1);
    localparam logic [10:0] V_FP_END  = 11'(V_ACTIVE + V_FP - 1);
    localparam logic [10:0] V_SYN_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);

    typedef enum logic [1:0] {H_ACT, H_FPO, H_SYN, H_BPO} h_phase_t;
    typedef enum logic [1:0] {V_ACT, V_FPO, V_SYN, V_BPO} v_phase_t;

    logic [10:0]      h_cnt;
    logic [10:0]      v_cnt;
    h_phase_t         h_state;
    v_phase_t         v_state;
    logic             h_wrap;
    logic             v_wrap;
    logic             active;
    logic             hsync_raw;
    logic             vsync_raw;
    logic [DLY_W-1:0] h_pipe;
    logic [DLY_W-1:0] v_pipe;

    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign active    = (h_state == H_ACT) && (v_state == V_ACT);
    assign hsync_raw = (h_state == H_SYN) ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw = (v_state == V_SYN) ? SYNC_POL : ~SYNC_POL;

    // Counters and phase FSMs; the vertical FSM only steps on a line wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else if (pix_en) begin
            h_cnt <= h_wrap ? '0 : h_cnt + 11'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 11'd1;
            end

            case (h_state)
                H_ACT:   if (h_cnt == H_ACT_END) h_state <= H_FPO;
                H_FPO:   if (h_cnt == H_FP_END)  h_state <= H_SYN;
                H_SYN:   if (h_cnt == H_SYN_END) h_state <= H_BPO;
                H_BPO:   if (h_wrap)             h_state <= H_ACT;
                default: h_state <= H_ACT;
            endcase

            if (h_wrap) begin
                case (v_state)
                    V_ACT:   if (v_cnt == V_ACT_END) v_state <= V_FPO;
                    V_FPO:   if (v_cnt == V_FP_END)  v_state <= V_SYN;
                    V_SYN:   if (v_cnt == V_SYN_END) v_state <= V_BPO;
                    V_BPO:   if (v_wrap)             v_state <= V_ACT;
                    default: v_state <= V_ACT;
                endcase
            end
        end
    end

    // Stage 0 of each sync pipe sits alongside ready; the rest is the extra delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready       <= 1'b0;
            col_addr    <= '0;
            row_addr    <= '0;
            frame_start <= 1'b0;
            h_pipe      <= {DLY_W{~SYNC_POL}};
            v_pipe      <= {DLY_W{~SYNC_POL}};
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                ready       <= active;
                col_addr    <= active ? h_cnt : '0;
                row_addr    <= active ? v_cnt : '0;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                h_pipe      <= DLY_W'({h_pipe, hsync_raw});
                v_pipe      <= DLY_W'({v_pipe, vsync_raw});
            end
        end
    end

    assign hsync = h_pipe[SYNC_DLY];
    assign vsync = v_pipe[SYNC_DLY];

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a small raster (14x8) with sync delay 0 and 2,
// plus the default 640x480 configuration sharing the same stimulus.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic [10:0] s_col, s_row, d_col, d_row, f_col, f_row;
    logic s_rdy, s_hs, s_vs, s_fs;
    logic d_rdy, d_hs, d_vs, d_fs;
    logic f_rdy, f_hs, f_vs, f_fs;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .SYNC_DLY(0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .col_addr(s_col), .row_addr(s_row), .ready(s_rdy),
        .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .SYNC_DLY(2)
    ) u_dly2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .col_addr(d_col), .row_addr(d_row), .ready(d_rdy),
        .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_timing u_dflt (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .col_addr(f_col), .row_addr(f_row), .ready(f_rdy),
        .hsync(f_hs), .vsync(f_vs), .frame_start(f_fs)
    );

    task automatic chk11(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_small(input string tag);
        chk1 ({tag, "_rdy"}, s_rdy, 1'b0);
        chk11({tag, "_col"}, s_col, 11'd0);
        chk11({tag, "_row"}, s_row, 11'd0);
        chk1 ({tag, "_fs"},  s_fs,  1'b0);
        chk1 ({tag, "_hs"},  s_hs,  1'b1);
        chk1 ({tag, "_vs"},  s_vs,  1'b1);
        chk1 ({tag, "_d_hs"}, d_hs, 1'b1);
        chk1 ({tag, "_d_vs"}, d_vs, 1'b1);
    endtask

    initial begin
        int n, m, h, v, h2, v2;
        logic e_rdy;
        int vs_first = 0;
        int vs_len   = 0;
        int hs_first = 0;
        int hs_len   = 0;
        int fs_cnt   = 0;
        int fs_last  = 0;

        // Reset held for three clocks with pix_en high.
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (3) tick();
        chk_reset_small("rst");
        chk1 ("rst_f_rdy", f_rdy, 1'b0);
        chk11("rst_f_col", f_col, 11'd0);
        chk11("rst_f_row", f_row, 11'd0);
        chk1 ("rst_f_fs",  f_fs,  1'b0);
        chk1 ("rst_f_hs",  f_hs,  1'b1);
        chk1 ("rst_f_vs",  f_vs,  1'b1);

        // Two full small frames, pix_en tied high.
        rst_n = 1'b1;
        for (int t = 1; t <= 224; t++) begin
            tick();
            n = t - 1;
            h = n % 14;
            v = (n / 14) % 8;
            e_rdy = (h < 8) && (v < 4);
            chk1 ("s_rdy", s_rdy, e_rdy);
            chk11("s_col", s_col, e_rdy ? 11'(h) : 11'd0);
            chk11("s_row", s_row, e_rdy ? 11'(v) : 11'd0);
            chk1 ("s_hs",  s_hs,  !(h >= 10 && h <= 12));
            chk1 ("s_vs",  s_vs,  !(v >= 5 && v <= 6));
            chk1 ("s_fs",  s_fs,  (h == 0) && (v == 0));

            chk1 ("d_rdy", d_rdy, e_rdy);
            chk11("d_col", d_col, e_rdy ? 11'(h) : 11'd0);
            m = n - 2;
            if (m < 0) begin
                chk1("d_hs", d_hs, 1'b1);
                chk1("d_vs", d_vs, 1'b1);
            end else begin
                h2 = m % 14;
                v2 = (m / 14) % 8;
                chk1("d_hs", d_hs, !(h2 >= 10 && h2 <= 12));
                chk1("d_vs", d_vs, !(v2 >= 5 && v2 <= 6));
            end

            chk11("f_col", f_col, 11'(n));
            chk1 ("f_rdy", f_rdy, 1'b1);
            chk1 ("f_hs",  f_hs,  1'b1);
            chk1 ("f_fs",  f_fs,  t == 1);

            if (!s_hs && t <= 14) begin
                if (hs_first == 0) hs_first = t;
                hs_len++;
            end
            if (!s_vs && t <= 112) begin
                if (vs_first == 0) vs_first = t;
                vs_len++;
            end
            if (s_fs) begin
                fs_cnt++;
                fs_last = t;
            end
        end
        chk11("hs_first_tick", 11'(hs_first), 11'd11);
        chk11("hs_width",      11'(hs_len),   11'd3);
        chk11("vs_first_tick", 11'(vs_first), 11'd71);
        chk11("vs_width",      11'(vs_len),   11'd28);
        chk11("fs_count",      11'(fs_cnt),   11'd2);
        chk11("fs_last_tick",  11'(fs_last),  11'd113);

        // pix_en 1,0,0,1 at the start of frame 3.
        tick();
        chk11("tg_col0", s_col, 11'd0);
        chk1 ("tg_fs0",  s_fs,  1'b1);
        pix_en = 1'b0;
        tick();
        chk11("tg_col_h1", s_col, 11'd0);
        chk1 ("tg_rdy_h1", s_rdy, 1'b1);
        chk1 ("tg_fs_h1",  s_fs,  1'b0);
        tick();
        chk11("tg_col_h2", s_col, 11'd0);
        chk1 ("tg_fs_h2",  s_fs,  1'b0);
        pix_en = 1'b1;
        tick();
        chk11("tg_col1", s_col, 11'd1);
        chk1 ("tg_fs1",  s_fs,  1'b0);

        // Reset mid-frame with internal count at h=5, v=2.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (33) tick();
        chk11("mid_col", s_col, 11'd4);
        chk11("mid_row", s_row, 11'd2);
        chk1 ("mid_rdy", s_rdy, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_reset_small("mrst");
        rst_n = 1'b1;
        tick();
        chk11("rel_col", s_col, 11'd0);
        chk11("rel_row", s_row, 11'd0);
        chk1 ("rel_rdy", s_rdy, 1'b1);
        chk1 ("rel_fs",  s_fs,  1'b1);
        chk1 ("rel_d_hs", d_hs, 1'b1);
        tick();
        chk11("rel_col1", s_col, 11'd1);
        chk1 ("rel_fs1",  s_fs,  1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
